// File: rtl/branch_stack.sv
// branch_stack: branch checkpoint store, one slot per branch-mask bit.
// Dispatch writes checkpoints into freshly allocated slots; execute resolves
// branches. A correct resolve broadcasts the mask bit to clear. A mispredict
// returns the resolved slot's checkpoint in the same cycle and squashes the
// slot together with every live slot that depends on it.
//
// Ports:
//   clock, reset             clock, asynchronous active-high reset
//   next_b_mask              dispatch's mask after this cycle's allocations
//   branch_stack_entries     per-slot checkpoint offered by dispatch
//   resolve_valid/_id/_mispredict  branch resolution from execute (id one-hot)
//   retire_free_mask         physical registers freed by retire this cycle
//   b_mask_combinational     live mask after this cycle's resolution
//   restore_valid            mispredict recovery this cycle
//   map_table_restore, free_list_restore, rob_tail_restore, recovery_pc
//                            checkpoint of the mispredicted branch
//   squash_mask              slots killed by the mispredict
//   clear_mask               bit to clear from b_masks on a correct resolve

package branch_stack_pkg;
    localparam int B_MASK_WIDTH = 4;
    localparam int ARCH_REG_SZ  = 32;
    localparam int PHYS_REG_SZ  = 64;
    localparam int ROB_SZ       = 32;
    localparam int PHYS_REG_IDX = $clog2(PHYS_REG_SZ);
    localparam int ROB_IDX      = $clog2(ROB_SZ);

    typedef struct packed {
        logic [31:0]                                recovery_pc;
        logic [ROB_IDX-1:0]                         rob_tail;
        logic [PHYS_REG_SZ-1:0]                     free_list;
        logic [ARCH_REG_SZ-1:0][PHYS_REG_IDX-1:0]   map_table;
        logic [B_MASK_WIDTH-1:0]                    b_m;
    } bs_entry_t;
endpackage

module branch_stack
    import branch_stack_pkg::*;
(
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic [B_MASK_WIDTH-1:0]                 next_b_mask,
    input  bs_entry_t [B_MASK_WIDTH-1:0]            branch_stack_entries,
    input  logic                                    resolve_valid,
    input  logic [B_MASK_WIDTH-1:0]                 resolve_id,
    input  logic                                    resolve_mispredict,
    input  logic [PHYS_REG_SZ-1:0]                  retire_free_mask,
    output logic [B_MASK_WIDTH-1:0]                 b_mask_combinational,
    output logic                                    restore_valid,
    output logic [ARCH_REG_SZ-1:0][PHYS_REG_IDX-1:0] map_table_restore,
    output logic [PHYS_REG_SZ-1:0]                  free_list_restore,
    output logic [ROB_IDX-1:0]                      rob_tail_restore,
    output logic [31:0]                             recovery_pc,
    output logic [B_MASK_WIDTH-1:0]                 squash_mask,
    output logic [B_MASK_WIDTH-1:0]                 clear_mask
);

    logic [B_MASK_WIDTH-1:0] b_mask;
    bs_entry_t               entries [B_MASK_WIDTH];

    logic                    effective;
    logic                    mispredict;
    logic                    correct;
    logic [B_MASK_WIDTH-1:0] dependents;
    logic [B_MASK_WIDTH-1:0] alloc;

    logic [31:0]                              sel_pc;
    logic [ROB_IDX-1:0]                       sel_tail;
    logic [PHYS_REG_SZ-1:0]                   sel_free;
    logic [ARCH_REG_SZ-1:0][PHYS_REG_IDX-1:0] sel_map;

    // Resolves aimed at a dead slot are dropped entirely.
    assign effective  = resolve_valid && ((resolve_id & b_mask) != '0);
    assign mispredict = effective && resolve_mispredict;
    assign correct    = effective && !resolve_mispredict;

    always_comb begin
        sel_pc     = '0;
        sel_tail   = '0;
        sel_free   = '0;
        sel_map    = '0;
        dependents = '0;
        for (int k = 0; k < B_MASK_WIDTH; k++) begin
            if (resolve_id[k]) begin
                sel_pc   = entries[k].recovery_pc;
                sel_tail = entries[k].rob_tail;
                sel_free = entries[k].free_list;
                sel_map  = entries[k].map_table;
            end
            if (b_mask[k] && ((entries[k].b_m & resolve_id) != '0))
                dependents[k] = 1'b1;
        end
    end

    always_comb begin
        restore_valid     = mispredict;
        squash_mask       = mispredict ? (resolve_id | dependents) : '0;
        clear_mask        = correct ? resolve_id : '0;
        map_table_restore = mispredict ? sel_map : '0;
        rob_tail_restore  = mispredict ? sel_tail : '0;
        recovery_pc       = mispredict ? sel_pc : '0;
        // Registers retired this very cycle must also return to the freelist.
        free_list_restore = mispredict ? (sel_free | retire_free_mask) : '0;
        b_mask_combinational = b_mask & ~squash_mask & ~clear_mask;
    end

    assign alloc = next_b_mask & ~b_mask_combinational;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            b_mask <= '0;
            for (int k = 0; k < B_MASK_WIDTH; k++)
                entries[k] <= '0;
        end else if (mispredict) begin
            // Dispatch is held off during recovery, so its inputs are ignored.
            b_mask <= b_mask & ~squash_mask;
            for (int k = 0; k < B_MASK_WIDTH; k++) begin
                if (squash_mask[k])
                    entries[k] <= '0;
                else if (b_mask[k])
                    entries[k].free_list <= entries[k].free_list | retire_free_mask;
            end
        end else begin
            b_mask <= next_b_mask;
            for (int k = 0; k < B_MASK_WIDTH; k++) begin
                if (alloc[k]) begin
                    entries[k]           <= branch_stack_entries[k];
                    entries[k].free_list <= branch_stack_entries[k].free_list | retire_free_mask;
                end else if (b_mask[k]) begin
                    entries[k].free_list <= entries[k].free_list | retire_free_mask;
                    if (correct)
                        entries[k].b_m <= entries[k].b_m & ~resolve_id;
                end
            end
        end
    end

endmodule
